state_serial_ctrl: RTL
======================

Name: state_serial_ctrl

Overview:
- Sequencer for the byte-serial Skinny round datapath in the Romulus core.
- Drives the datapath's per-row shift enables, chain/mxc/mode/rst/dec selects and the per-byte round constant.
- Runs four operations: ENC (all rounds), ABSORB, ABSORB_DEC and ZERO.
- Sits between the top-level mode FSM (start/op/done) and the state and tweakey serial datapaths.

Parameters:
- ROUNDS, 40, number of Skinny rounds per ENC, range 1..63.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle command strobe, sampled only in IDLE.
- op  in  2  command: 00 ENC, 01 ABSORB, 10 ABSORB_DEC, 11 ZERO.
- din_valid  in  1  a pdi byte is present (ABSORB/ABSORB_DEC).
- din_ready  out  1  byte accepted this cycle when din_valid is also high.
- en  out  4  per-row shift enable to the state datapath.
- chain  out  1  serial chain select.
- mxc  out  1  MixColumns select.
- mode  out  1  1 = load path (pdi xor state), 0 = SB/ATK path.
- st_rst  out  1  zero-load select for the state datapath.
- dec  out  1  decrypt feedback select.
- con  out  8  round constant byte for the current cycle.
- tk_row  out  1  high while the key byte is valid (SB cycles 0..7).
- rnd  out  6  current round index, 0-based.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE. All outputs 0 except chain=1. rc=6'h01, cnt=0, rnd=0. Reset mid-operation aborts immediately; no done pulse.
- IDLE: en=0, busy=0. start=1 moves to the state selected by op on the next cycle. start is ignored when not in IDLE.
- ZERO: 16 cycles with en=4'hF, chain=1, mode=1, st_rst=1. done pulses on the cycle after the 16th shift, with return to IDLE.
- ABSORB / ABSORB_DEC:
  - chain=1, mode=1, din_ready=1, dec=(op==10).
  - en=4'hF only in cycles where din_valid=1; the byte counter advances only then.
  - After 16 accepted bytes: done pulse, return to IDLE.
  - din_valid low stalls indefinitely with en=0.
- ENC: rounds r=0..ROUNDS-1, each exactly 23 cycles, no bubbles between rounds.
  - SB phase, 16 cycles k=0..15: en=4'hF, chain=1, mode=0.
    - con=({4'h0,rc[3:0]}) at k=0, ({6'h0,rc[5:4]}) at k=4, 8'h02 at k=8, 0 otherwise.
    - tk_row=(k<8).
  - SR phase, 3 cycles: chain=0, mxc=0, en=4'b0111, then 4'b0011, then 4'b0001. This rotates row 1 by one byte, row 2 by two and row 3 by three.
  - MC phase, 4 cycles: chain=0, mxc=1, en=4'hF.
  - At the last MC cycle:
    - rc <= {rc[4:0], rc[5]^rc[4]^1'b1}.
    - rnd increments.
    - If rnd==ROUNDS-1: done pulses the next cycle, state returns to IDLE, rc reloads 6'h01, rnd clears.
- Total ENC latency: 23*ROUNDS cycles from the first SB cycle. The first SB cycle is the cycle after start.
- con, tk_row, mxc and dec are 0 outside their phases.
- Counters: cnt is 5-bit, cleared on every phase transition. Phase transitions are decided on cnt terminal values 15/2/3.
- busy is high from the cycle after start through the done cycle. done is never asserted together with busy=0 in the same cycle as start acceptance.

Optional Feature:
- Macro SCTL_HOLD_EN.
- Defined:
  - Adds input port hold (1 bit).
  - In ENC, hold=1 forces en=0, con=0, tk_row=0 and freezes cnt, rc, rnd and the phase. The sequence resumes exactly where it stopped.
  - hold is ignored in IDLE, ZERO and ABSORB*.
- Not defined: no hold port; ENC runs uninterrupted.

Test Plan:
- Reset: hold rst_n=0 two cycles. Required: en=0, chain=1, busy=0, done=0, rnd=0. Then start with op=00: first cycle en=4'hF, mode=0, con=8'h01.
- ENC, ROUNDS=40: done exactly 920 cycles after the first SB cycle.
  - Round 1 SB k=0 con=8'h03; round 2 k=0 con=8'h07.
  - Per round: 16 cycles en=F, then SR en sequence 7,3,1, then 4 cycles mxc=1.
- ABSORB with din_valid toggling 1,0,1,0...: din_ready=1 throughout. en=F only on valid cycles. done after the 16th valid byte, i.e. 31 cycles after the first.
- ABSORB_DEC: dec=1 for all 16 byte cycles, 0 afterwards. ZERO: st_rst=1 for exactly 16 cycles, then done.
- Reset mid-operation: rst_n=0 at ENC round 5, SR phase. Next cycle: IDLE outputs, no done. A new ENC starts with con=8'h01.
- SCTL_HOLD_EN: hold=1 for 10 cycles at round 0, k=4. en=0 and con=0 during the hold. After release, con=8'h00 (rc[5:4]=0) at k=4. done is delayed by exactly 10 cycles (930 total).

Source files
------------

// File: rtl/state_serial_ctrl.sv
// state_serial_ctrl: sequencer for the byte-serial Skinny round datapath.
// Runs ENC (ROUNDS rounds of SB/SR/MC), ABSORB, ABSORB_DEC and ZERO.
// Optional macro SCTL_HOLD_EN adds a 'hold' input that freezes ENC in place.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; en=0, busy=0 (except on the done cycle)
// ZERO   | 16 shifts loading zeros into the state
// ABS    | absorbing 16 pdi bytes, one per din_valid cycle (dec for DEC)
// SB     | 16 cycles of SubCells/AddConstant/AddRoundTweakey, all rows
// SR     | 3 cycles of ShiftRows via partial row enables 7,3,1
// MC     | 4 cycles of MixColumns
module state_serial_ctrl #(
  parameter int ROUNDS = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       din_valid,
`ifdef SCTL_HOLD_EN
  input  logic       hold,
`endif
  output logic       din_ready,
  output logic [3:0] en,
  output logic       chain,
  output logic       mxc,
  output logic       mode,
  output logic       st_rst,
  output logic       dec,
  output logic [7:0] con,
  output logic       tk_row,
  output logic [5:0] rnd,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ZERO, S_ABS, S_SB, S_SR, S_MC
  } state_t;

  localparam logic [5:0] RND_LAST = 6'(ROUNDS - 1);

  state_t     state;
  logic [4:0] cnt;
  logic [5:0] rc;
  logic       dec_q;
  logic       hold_i;

`ifdef SCTL_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  // Phase sequencing, counters, round constant LFSR and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
      rc    <= 6'h01;
      rnd   <= 6'd0;
      dec_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt   <= 5'd0;
            dec_q <= (op == 2'b10);
            case (op)
              2'b00:   state <= S_SB;
              2'b01:   state <= S_ABS;
              2'b10:   state <= S_ABS;
              default: state <= S_ZERO;
            endcase
          end
        end
        S_ZERO: begin
          if (cnt == 5'd15) begin
            cnt   <= 5'd0;
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_ABS: begin
          if (din_valid) begin
            if (cnt == 5'd15) begin
              cnt   <= 5'd0;
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        S_SB: begin
          if (!hold_i) begin
            if (cnt == 5'd15) begin
              cnt   <= 5'd0;
              state <= S_SR;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        S_SR: begin
          if (!hold_i) begin
            if (cnt == 5'd2) begin
              cnt   <= 5'd0;
              state <= S_MC;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        S_MC: begin
          if (!hold_i) begin
            if (cnt == 5'd3) begin
              cnt <= 5'd0;
              if (rnd == RND_LAST) begin
                state <= S_IDLE;
                done  <= 1'b1;
                rc    <= 6'h01;
                rnd   <= 6'd0;
              end else begin
                state <= S_SB;
                rc    <= {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
                rnd   <= rnd + 6'd1;
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath selects decoded from the current phase; en is gated by
  // din_valid in ABS and by hold in the ENC phases within the same cycle.
  always_comb begin
    en        = 4'h0;
    chain     = 1'b1;
    mxc       = 1'b0;
    mode      = 1'b0;
    st_rst    = 1'b0;
    dec       = 1'b0;
    con       = 8'h00;
    tk_row    = 1'b0;
    din_ready = 1'b0;
    busy      = (state != S_IDLE) || done;
    case (state)
      S_ZERO: begin
        en     = 4'hF;
        mode   = 1'b1;
        st_rst = 1'b1;
      end
      S_ABS: begin
        din_ready = 1'b1;
        mode      = 1'b1;
        dec       = dec_q;
        en        = din_valid ? 4'hF : 4'h0;
      end
      S_SB: begin
        if (!hold_i) begin
          en     = 4'hF;
          tk_row = (cnt < 5'd8);
          case (cnt)
            5'd0:    con = {4'h0, rc[3:0]};
            5'd4:    con = {6'h0, rc[5:4]};
            5'd8:    con = 8'h02;
            default: con = 8'h00;
          endcase
        end
      end
      S_SR: begin
        chain = 1'b0;
        if (!hold_i) begin
          case (cnt)
            5'd0:    en = 4'b0111;
            5'd1:    en = 4'b0011;
            default: en = 4'b0001;
          endcase
        end
      end
      S_MC: begin
        chain = 1'b0;
        mxc   = 1'b1;
        if (!hold_i) en = 4'hF;
      end
      default: ;
    endcase
  end

endmodule
